// File: rtl/pc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_ctrl_pkg
// Description : Shared constants and state encodings for the PC/branch control
// Revision    : 1.0 - initial release
// ============================================================================
package pc_ctrl_pkg;

    localparam int PC_STEP     = 4;
    localparam int IMM_W       = 16;
    localparam int JIDX_W      = 26;
    localparam int FLUSH_CNT_W = 3;

    typedef logic [1:0] state_t;

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

endpackage
`default_nettype wire

// File: rtl/br_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : br_target_calc
// Description : Combinational branch and jump target computation
// Revision    : 1.0 - initial release
// ============================================================================
module br_target_calc
    import pc_ctrl_pkg::*;
(
    input  logic [31:0]       br_pc_i,
    input  logic [IMM_W-1:0]  br_imm_i,
    input  logic [JIDX_W-1:0] jmp_idx_i,
    output logic [31:0]       btgt,
    output logic [31:0]       jtgt
);

    logic [31:0] w_pc_plus4;
    logic [31:0] w_imm_off;

    assign w_pc_plus4 = br_pc_i + 32'(PC_STEP);
    // Word offset: sign-extend the immediate and scale to bytes.
    assign w_imm_off  = {{(32-IMM_W-2){br_imm_i[IMM_W-1]}}, br_imm_i, 2'b00};
    assign btgt       = w_pc_plus4 + w_imm_off;
    assign jtgt       = {w_pc_plus4[31:28], jmp_idx_i, 2'b00};

endmodule
`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_branch_ctrl
// Description : Program counter owner, branch/jump redirect and flush sequencer
// Revision    : 1.0 - initial release
// ============================================================================
module pc_branch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              imem_ready_i,
    input  logic              br_valid_i,
    input  logic              br_taken_i,
    input  logic [31:0]       br_pc_i,
    input  logic [IMM_W-1:0]  br_imm_i,
    input  logic              jmp_valid_i,
    input  logic [JIDX_W-1:0] jmp_idx_i,
    output logic [31:0]       pc_o,
    output logic              pc_valid_o,
    output logic              flush_o,
    output logic              redirect_o,
    output logic [CNT_W-1:0]  redirect_cnt_o
);

    localparam logic [FLUSH_CNT_W-1:0] c_flush_init = FLUSH_CNT_W'(FLUSH_CYCLES);

    state_t                 r_state;
    logic [31:0]            r_pc;
    logic                   r_pc_valid;
    logic                   r_flush;
    logic                   r_redirect;
    logic [CNT_W-1:0]       r_cnt;
    logic [FLUSH_CNT_W-1:0] r_fcnt;

    logic [31:0] w_btgt;
    logic [31:0] w_jtgt;
    logic        w_br_take;
    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_seq;

    br_target_calc u_tgt (
        .br_pc_i   (br_pc_i),
        .br_imm_i  (br_imm_i),
        .jmp_idx_i (jmp_idx_i),
        .btgt      (w_btgt),
        .jtgt      (w_jtgt)
    );

    // A taken branch outranks a simultaneous jump.
    assign w_br_take  = br_valid_i & br_taken_i;
    assign w_redirect = w_br_take | jmp_valid_i;
    assign w_target   = w_br_take ? w_btgt : w_jtgt;
    assign w_seq      = r_pc + 32'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
            r_cnt      <= '0;
            r_fcnt     <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= FETCH;
                    r_pc_valid <= 1'b1;
                end
                FETCH: begin
                    r_redirect <= 1'b0;
                    if (w_redirect) begin
                        r_pc       <= w_target;
                        r_redirect <= 1'b1;
                        r_flush    <= 1'b1;
                        r_pc_valid <= 1'b0;
                        r_fcnt     <= c_flush_init;
                        r_state    <= FLUSH;
                        if (r_cnt != {CNT_W{1'b1}}) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (!stall_i && imem_ready_i) begin
                        r_pc <= w_seq;
                    end
                end
                FLUSH: begin
                    // EX holds only bubbles here, so all requests are ignored.
                    r_redirect <= 1'b0;
                    if (r_fcnt == FLUSH_CNT_W'(1)) begin
                        r_state    <= FETCH;
                        r_flush    <= 1'b0;
                        r_pc_valid <= 1'b1;
                    end else begin
                        r_fcnt <= r_fcnt - FLUSH_CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= BOOT;
                    r_pc_valid <= 1'b0;
                    r_flush    <= 1'b0;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    assign pc_o           = r_pc;
    assign pc_valid_o     = r_pc_valid;
    assign flush_o        = r_flush;
    assign redirect_o     = r_redirect;
    assign redirect_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_branch_ctrl
// Description : Directed self-checking bench for pc_branch_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_branch_ctrl;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        imem_ready_i;
    logic        br_valid_i;
    logic        br_taken_i;
    logic [31:0] br_pc_i;
    logic [15:0] br_imm_i;
    logic        jmp_valid_i;
    logic [25:0] jmp_idx_i;

    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        flush_o;
    logic        redirect_o;
    logic [15:0] redirect_cnt_o;

    logic [31:0] s_pc;
    logic        s_pc_valid;
    logic        s_flush;
    logic        s_redirect;
    logic [3:0]  s_cnt;

    int n_vec = 0;
    int n_err = 0;

    pc_branch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .imem_ready_i   (imem_ready_i),
        .br_valid_i     (br_valid_i),
        .br_taken_i     (br_taken_i),
        .br_pc_i        (br_pc_i),
        .br_imm_i       (br_imm_i),
        .jmp_valid_i    (jmp_valid_i),
        .jmp_idx_i      (jmp_idx_i),
        .pc_o           (pc_o),
        .pc_valid_o     (pc_valid_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .redirect_cnt_o (redirect_cnt_o)
    );

    // Narrow counter and single-cycle flush for saturation and minimum-flush checks.
    pc_branch_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .imem_ready_i   (imem_ready_i),
        .br_valid_i     (br_valid_i),
        .br_taken_i     (br_taken_i),
        .br_pc_i        (br_pc_i),
        .br_imm_i       (br_imm_i),
        .jmp_valid_i    (jmp_valid_i),
        .jmp_idx_i      (jmp_idx_i),
        .pc_o           (s_pc),
        .pc_valid_o     (s_pc_valid),
        .flush_o        (s_flush),
        .redirect_o     (s_redirect),
        .redirect_cnt_o (s_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ev();
        br_valid_i  = 1'b0;
        br_taken_i  = 1'b0;
        jmp_valid_i = 1'b0;
        stall_i     = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic v,
                           input logic f, input logic r);
        chk({tag, "_pc"},    pc_o,       pc);
        chk({tag, "_valid"}, 32'(pc_valid_o), 32'(v));
        chk({tag, "_flush"}, 32'(flush_o),    32'(f));
        chk({tag, "_redir"}, 32'(redirect_o), 32'(r));
    endtask

    initial begin
        int sat_pulses;
        int main_pulses;
        int cyc;
        logic [3:0] cnt_at15;

        rst          = 1'b1;
        imem_ready_i = 1'b1;
        br_pc_i      = '0;
        br_imm_i     = '0;
        jmp_idx_i    = '0;
        cnt_at15     = '0;
        clr_ev();

        #3;
        chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("reset_cnt", 32'(redirect_cnt_o), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot_valid", 32'(pc_valid_o), 32'h0);

        for (int i = 0; i < 4; i++) begin
            tick();
            chk_out($sformatf("seq%0d", i), 32'(4 * i), 1'b1, 1'b0, 1'b0);
        end

        // Backward branch: 0x44 - 8 = 0x3C.
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_pc_i = 32'h40; br_imm_i = 16'hFFFE;
        tick();
        clr_ev();
        chk_out("bwd_c1", 32'h3C, 1'b0, 1'b1, 1'b1);
        chk("bwd_cnt", 32'(redirect_cnt_o), 32'd1);
        tick();
        chk_out("bwd_c2", 32'h3C, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("bwd_c3", 32'h3C, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("bwd_seq", 32'h40, 1'b1, 1'b0, 1'b0);

        // Not-taken branch has no effect.
        br_valid_i = 1'b1; br_taken_i = 1'b0; br_pc_i = 32'hFFFF_FFF8; br_imm_i = 16'h0004;
        tick();
        chk_out("nt", 32'h44, 1'b1, 1'b0, 1'b0);

        // Taken at wrap: 0xFFFFFFFC + 0x10 wraps to 0x0000000C.
        br_taken_i = 1'b1;
        tick();
        chk_out("wrap_c1", 32'h0000_000C, 1'b0, 1'b1, 1'b1);

        // Taken branch presented during FLUSH must be ignored.
        br_pc_i = 32'h100; br_imm_i = 16'h0000;
        tick();
        clr_ev();
        chk_out("ign_c2", 32'h0000_000C, 1'b0, 1'b1, 1'b0);
        chk("ign_cnt", 32'(redirect_cnt_o), 32'd2);
        tick();
        chk_out("wrap_c3", 32'h0000_000C, 1'b1, 1'b0, 1'b0);

        // Jump with simultaneous stall: redirect wins.
        jmp_valid_i = 1'b1; stall_i = 1'b1; br_pc_i = 32'h1000_0000; jmp_idx_i = 26'h0000100;
        tick();
        clr_ev();
        chk_out("jmp_c1", 32'h1000_0400, 1'b0, 1'b1, 1'b1);
        chk("jmp_cnt", 32'(redirect_cnt_o), 32'd3);
        tick();
        tick();
        chk_out("jmp_c3", 32'h1000_0400, 1'b1, 1'b0, 1'b0);

        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("stall%0d", i), 32'h1000_0400, 1'b1, 1'b0, 1'b0);
        end
        stall_i = 1'b0;
        imem_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out($sformatf("bp%0d", i), 32'h1000_0400, 1'b1, 1'b0, 1'b0);
        end
        imem_ready_i = 1'b1;
        tick();
        chk_out("bp_rel", 32'h1000_0404, 1'b1, 1'b0, 1'b0);

        // Async reset in the middle of a flush.
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_pc_i = 32'h200; br_imm_i = 16'h0001;
        tick();
        clr_ev();
        chk_out("pre_rst", 32'h208, 1'b0, 1'b1, 1'b1);
        chk("pre_rst_cnt", 32'(redirect_cnt_o), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        chk("async_rst_cnt", 32'(redirect_cnt_o), 32'h0);

        // Continuous taken branches drive the narrow counter into saturation.
        br_valid_i = 1'b1; br_taken_i = 1'b1; br_pc_i = 32'h0; br_imm_i = 16'h0;
        @(negedge clk);
        rst = 1'b0;
        sat_pulses  = 0;
        main_pulses = 0;
        cyc         = 0;
        while (sat_pulses < 17 && cyc < 100) begin
            tick();
            cyc++;
            chk("sat_flush_eq_redir", 32'(s_flush), 32'(s_redirect));
            if (s_redirect) begin
                sat_pulses++;
                if (sat_pulses == 15) cnt_at15 = s_cnt;
            end
            if (redirect_o) main_pulses++;
        end
        clr_ev();
        chk("sat_pulses", 32'(sat_pulses), 32'd17);
        chk("sat_cnt15", 32'(cnt_at15), 32'd15);
        chk("sat_cnt", 32'(s_cnt), 32'hF);
        chk("main_cnt", 32'(redirect_cnt_o), 32'(main_pulses));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
